// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: PC stream in, instruction-memory request/response, decode queue out.
// The fetch unit takes the master view; the surrounding core or bench takes the slave view.
interface instr_fetch_unit_if;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        redirect;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        err_unexp_rsp;

   modport master (
      input  pc_in, pc_valid, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             instr_ready,
      output pc_ready, imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
             err_unexp_rsp
   );

   modport slave (
      output pc_in, pc_valid, redirect, imem_req_ready, imem_rsp_valid, imem_rsp_data,
             instr_ready,
      input  pc_ready, imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
             err_unexp_rsp
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: issues word requests, tags responses with their PC and queues
// them for decode; a redirect flushes the queue and drops every response still in flight.
module instr_fetch_unit #(
   parameter int DEPTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   instr_fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [AW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
   logic [31:0]   tag_mem_q [DEPTH];
   logic [31:0]   tag_mem_d [DEPTH];
   logic [31:0]   q_data_q  [DEPTH];
   logic [31:0]   q_data_d  [DEPTH];
   logic [31:0]   q_pc_q    [DEPTH];
   logic [31:0]   q_pc_d    [DEPTH];
   logic          err_q, err_d;

   logic [CW:0]   occupancy;
   logic          credit_ok, req_valid, fire;
   logic          rsp_ok, rsp_unexp, rsp_drop, rsp_keep;
   logic          instr_vld, pop;

   // Credit uses registered occupancy only, so a same-cycle pop never frees a slot early.
   always_comb begin
      occupancy = {1'b0, inflight_q} + {1'b0, count_q};
      credit_ok = occupancy < DEPTH_OCC;
      req_valid = rst_n & bus.pc_valid & credit_ok & ~bus.redirect;
      fire      = req_valid & bus.imem_req_ready;
      rsp_ok    = bus.imem_rsp_valid & (inflight_q != '0);
      rsp_unexp = bus.imem_rsp_valid & (inflight_q == '0);
      rsp_drop  = rsp_ok & ((drop_cnt_q != '0) | bus.redirect);
      rsp_keep  = rsp_ok & ~rsp_drop;
      instr_vld = (count_q != '0) & ~bus.redirect;
      pop       = instr_vld & bus.instr_ready;
   end

   always_comb begin
      inflight_d = inflight_q + CW'(fire) - CW'(rsp_ok);
      tag_wr_d   = tag_wr_q + AW'(fire);
      tag_rd_d   = tag_rd_q + AW'(rsp_ok);
      tag_mem_d  = tag_mem_q;
      if (fire) tag_mem_d[tag_wr_q] = bus.pc_in;

      // Recomputed from the live count on every redirect, so back-to-back flushes never stack.
      drop_cnt_d = drop_cnt_q;
      if (bus.redirect)
         drop_cnt_d = inflight_q - CW'(rsp_ok);
      else if (rsp_ok && drop_cnt_q != '0)
         drop_cnt_d = drop_cnt_q - CW'(1);

      err_d = err_q | rsp_unexp;
   end

   always_comb begin
      q_data_d = q_data_q;
      q_pc_d   = q_pc_q;
      if (bus.redirect) begin
         count_d = '0;
         q_wr_d  = '0;
         q_rd_d  = '0;
      end else begin
         count_d = count_q + CW'(rsp_keep) - CW'(pop);
         q_wr_d  = q_wr_q + AW'(rsp_keep);
         q_rd_d  = q_rd_q + AW'(pop);
      end
      if (rsp_keep) begin
         q_data_d[q_wr_q] = bus.imem_rsp_data;
         q_pc_d[q_wr_q]   = tag_mem_q[tag_rd_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= '0;
         drop_cnt_q <= '0;
         count_q    <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         q_wr_q     <= '0;
         q_rd_q     <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_mem_q[i] <= '0;
            q_data_q[i]  <= '0;
            q_pc_q[i]    <= '0;
         end
      end else begin
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         count_q    <= count_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
         q_wr_q     <= q_wr_d;
         q_rd_q     <= q_rd_d;
         err_q      <= err_d;
         tag_mem_q  <= tag_mem_d;
         q_data_q   <= q_data_d;
         q_pc_q     <= q_pc_d;
      end
   end

   assign bus.imem_req_valid = req_valid;
   assign bus.pc_ready       = fire;
   assign bus.imem_req_addr  = {bus.pc_in[31:2], 2'b00};
   assign bus.instr_valid    = instr_vld;
   assign bus.instr_data     = q_data_q[q_rd_q];
   assign bus.instr_pc       = q_pc_q[q_rd_q];
   assign bus.err_unexp_rsp  = err_q;

endmodule
